mem_dump_streamer: RTL

MEM_DUMP_STREAMER -- requirements
Module: mem_dump_streamer

---
 rtl/mem_dump_streamer_pkg.sv | 15 +
 rtl/mem_dump_streamer_byte_packer.sv | 41 ++++
 rtl/mem_dump_streamer.sv | 103 ++++++++++
 3 files changed

// File: rtl/mem_dump_streamer_pkg.sv
// Shared FSM encoding and word geometry for the memory dump streamer.
package mem_dump_streamer_pkg;

    localparam int unsigned BytesPerWord = 4;
    localparam int unsigned IdxW         = $clog2(BytesPerWord);

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdCap,
        StSend,
        StDone
    } state_e;

endpackage

// File: rtl/mem_dump_streamer_byte_packer.sv
// Collects bytes into a big-endian word: the first byte captured lands in the top lane.
module mem_dump_streamer_byte_packer
    import mem_dump_streamer_pkg::*;
(
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic        clear_i,
    input  logic        cap_i,
    input  logic [7:0]  data_i,
    output logic [31:0] word_o,
    output logic        last_o
);

    logic [BytesPerWord-1:0][7:0] lanes_q, lanes_d;
    logic [IdxW-1:0]              idx_q, idx_d;

    always_comb begin
        lanes_d = lanes_q;
        idx_d   = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (cap_i) begin
            lanes_d[IdxW'(BytesPerWord - 1) - idx_q] = data_i;
            idx_d = idx_q + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            lanes_q <= '0;
            idx_q   <= '0;
        end else begin
            lanes_q <= lanes_d;
            idx_q   <= idx_d;
        end
    end

    assign word_o = lanes_q;
    assign last_o = (idx_q == IdxW'(BytesPerWord - 1));

endmodule

// File: rtl/mem_dump_streamer.sv
// Streams word_count big-endian 32-bit words read byte-by-byte from a one-cycle-latency memory.
module mem_dump_streamer
    import mem_dump_streamer_pkg::*;
#(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  word_count_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_en_o,
    input  logic [7:0]        mem_data_i,
    output logic [31:0]       out_word_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] off_q, off_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              pk_clear, pk_cap, pk_last;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        off_d    = off_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        pk_clear = 1'b0;
        pk_cap   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (word_count_i != '0) begin
                        base_d   = base_addr_i;
                        len_d    = word_count_i;
                        off_d    = '0;
                        cnt_d    = '0;
                        pk_clear = 1'b1;
                        state_d  = StRdAddr;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRdAddr: state_d = StRdCap;
            StRdCap: begin
                pk_cap  = 1'b1;
                // Offset wraps naturally at 2^ADDR_W.
                off_d   = off_q + ADDR_W'(1);
                state_d = pk_last ? StSend : StRdAddr;
            end
            StSend: begin
                if (out_ready_i) begin
                    cnt_d   = cnt_q + LEN_W'(1);
                    state_d = (cnt_q == len_q - LEN_W'(1)) ? StDone : StRdAddr;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q <= StIdle;
            base_q  <= '0;
            off_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            off_q   <= off_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    mem_dump_streamer_byte_packer byte_packer (
        .clk_i   (clk_i),
        .clr_i   (clr_i),
        .clear_i (pk_clear),
        .cap_i   (pk_cap),
        .data_i  (mem_data_i),
        .word_o  (out_word_o),
        .last_o  (pk_last)
    );

    assign mem_addr_o  = base_q + off_q;
    assign mem_rd_en_o = (state_q == StRdAddr);
    assign out_valid_o = (state_q == StSend);
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);

endmodule
